// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with configurable memory
// latency, IO-region decode, ecall IO handshake, sticky halt/trap and a retired counter.
module multicycle_controller #(
    parameter int                      IO_HIGH_BITS = 22,
    parameter logic [IO_HIGH_BITS-1:0] IO_PREFIX    = 22'h3FFFFE,
    parameter int                      MEM_WAIT     = 1,
    parameter int                      CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             inst,
    input  logic [IO_HIGH_BITS-1:0] alu_result_high,
    input  logic                    io_ack,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    reg_write,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    io_read,
    output logic                    io_write,
    output logic                    mem_or_io_to_reg,
    output logic                    alu_src,
    output logic                    jal,
    output logic                    jr,
    output logic                    branch,
    output logic [2:0]              alu_op,
    output logic                    io_req,
    output logic                    halted,
    output logic                    illegal,
    output logic [2:0]              state,
    output logic [CNT_W-1:0]        retired
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM  = 3'd3,
        S_WB    = 3'd4, S_ECALL  = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R = 4'd0, C_I = 4'd1, C_LOAD = 4'd2, C_STORE = 4'd3, C_BRANCH = 4'd4, C_JAL = 4'd5,
        C_JALR = 4'd6, C_LUI = 4'd7, C_AUIPC = 4'd8, C_SYS = 4'd9, C_BAD = 4'd10
    } class_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    function automatic class_t decode_class(input logic [6:0] opcode);
        case (opcode)
            7'b0110011: decode_class = C_R;
            7'b0010011: decode_class = C_I;
            7'b0000011: decode_class = C_LOAD;
            7'b0100011: decode_class = C_STORE;
            7'b1100011: decode_class = C_BRANCH;
            7'b1101111: decode_class = C_JAL;
            7'b1100111: decode_class = C_JALR;
            7'b0110111: decode_class = C_LUI;
            7'b0010111: decode_class = C_AUIPC;
            7'b1110011: decode_class = C_SYS;
            default:    decode_class = C_BAD;
        endcase
    endfunction

    state_t           state_r, state_nxt_s;
    logic [2:0]       wait_r;
    class_t           class_r;
    logic             is_io_r;
    logic [CNT_W-1:0] retired_r;

    logic   wait_done_s, is_sys_s, is_ebreak_s, unused_inst_s;
    class_t dec_class_s;
    logic   ir_write_s, pc_write_s, reg_write_s, mem_read_s, mem_write_s, io_read_s, io_write_s;
    logic   m2r_s, alu_src_s, jal_s, jr_s, branch_s, io_req_s, halted_s, illegal_s;
    logic [2:0] alu_op_s;

    assign wait_done_s   = (wait_r == WAIT_LAST);
    assign dec_class_s   = decode_class(inst[6:0]);
    assign is_sys_s      = (inst[6:0] == 7'b1110011);
    assign is_ebreak_s   = is_sys_s && (inst[31:20] == 12'd1);
    assign unused_inst_s = ^inst[19:7];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_FETCH;
        else     state_r <= state_nxt_s;
    end

    // Wait counter restarts on every state change, so FETCH and MEM always begin at zero
    always_ff @(posedge clk) begin
        if (rst)                                            wait_r <= 3'd0;
        else if (state_nxt_s != state_r)                    wait_r <= 3'd0;
        else if ((state_r == S_FETCH) || (state_r == S_MEM)) wait_r <= wait_r + 3'd1;
        else                                                wait_r <= wait_r;
    end

    // Instruction class captured in DECODE, IO-region flag captured in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            class_r <= C_R;
            is_io_r <= 1'b0;
        end else begin
            class_r <= (state_r == S_DECODE) ? dec_class_s : class_r;
            is_io_r <= (state_r == S_EXEC) ? (alu_result_high == IO_PREFIX) : is_io_r;
        end
    end

    // Retired-instruction counter: one count per pc_write, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst)             retired_r <= '0;
        else if (pc_write_s) retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        else                 retired_r <= retired_r;
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH:  state_nxt_s = wait_done_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_ebreak_s)                state_nxt_s = S_HALT;
                else if (is_sys_s)              state_nxt_s = S_ECALL;
                else if (dec_class_s == C_BAD)  state_nxt_s = S_TRAP;
                else                            state_nxt_s = S_EXEC;
            end
            S_EXEC: begin
                case (class_r)
                    C_BRANCH:        state_nxt_s = S_FETCH;
                    C_LOAD, C_STORE: state_nxt_s = S_MEM;
                    default:         state_nxt_s = S_WB;
                endcase
            end
            S_MEM: begin
                if (!wait_done_s)            state_nxt_s = S_MEM;
                else if (class_r == C_STORE) state_nxt_s = S_FETCH;
                else                         state_nxt_s = S_WB;
            end
            S_WB:     state_nxt_s = S_FETCH;
            S_ECALL:  state_nxt_s = io_ack ? S_FETCH : S_ECALL;
            S_HALT:   state_nxt_s = S_HALT;
            S_TRAP:   state_nxt_s = S_TRAP;
            default:  state_nxt_s = S_FETCH;
        endcase
    end

    // Output decode; rst silences every strobe immediately so an aborted access issues nothing
    always_comb begin
        ir_write_s = 1'b0; pc_write_s = 1'b0; reg_write_s = 1'b0; mem_read_s = 1'b0;
        mem_write_s = 1'b0; io_read_s = 1'b0; io_write_s = 1'b0; m2r_s = 1'b0;
        alu_src_s = 1'b0; jal_s = 1'b0; jr_s = 1'b0; branch_s = 1'b0; alu_op_s = 3'b000;
        io_req_s = 1'b0; halted_s = 1'b0; illegal_s = 1'b0;
        if (rst) begin
            pc_write_s = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: ir_write_s = wait_done_s;
                S_EXEC: begin
                    alu_src_s = (class_r inside {C_I, C_LOAD, C_STORE, C_JAL, C_JALR, C_LUI, C_AUIPC});
                    case (class_r)
                        C_R, C_I: alu_op_s = 3'b010;
                        C_BRANCH: alu_op_s = 3'b001;
                        C_LUI:    alu_op_s = 3'b011;
                        C_AUIPC:  alu_op_s = 3'b110;
                        default:  alu_op_s = 3'b000;
                    endcase
                    branch_s   = (class_r == C_BRANCH);
                    pc_write_s = (class_r == C_BRANCH);
                end
                S_MEM: begin
                    mem_read_s  = (class_r == C_LOAD)  && !is_io_r;
                    io_read_s   = (class_r == C_LOAD)  &&  is_io_r;
                    mem_write_s = (class_r == C_STORE) && !is_io_r;
                    io_write_s  = (class_r == C_STORE) &&  is_io_r;
                    pc_write_s  = (class_r == C_STORE) && wait_done_s;
                end
                S_WB: begin
                    reg_write_s = 1'b1;
                    pc_write_s  = 1'b1;
                    m2r_s       = (class_r == C_LOAD);
                    jal_s       = (class_r == C_JAL) || (class_r == C_JALR);
                    jr_s        = (class_r == C_JALR);
                end
                S_ECALL: begin
                    io_write_s = 1'b1;
                    io_req_s   = 1'b1;
                    alu_op_s   = 3'b100;
                    alu_src_s  = 1'b1;
                    pc_write_s = io_ack;
                end
                S_HALT:  halted_s  = 1'b1;
                S_TRAP:  illegal_s = 1'b1;
                default: ir_write_s = 1'b0;
            endcase
        end
    end

    assign ir_write = ir_write_s;   assign pc_write = pc_write_s;   assign reg_write = reg_write_s;
    assign mem_read = mem_read_s;   assign mem_write = mem_write_s; assign io_read = io_read_s;
    assign io_write = io_write_s;   assign mem_or_io_to_reg = m2r_s; assign alu_src = alu_src_s;
    assign jal = jal_s;             assign jr = jr_s;               assign branch = branch_s;
    assign alu_op = alu_op_s;       assign io_req = io_req_s;       assign halted = halted_s;
    assign illegal = illegal_s;     assign state = state_r;         assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (MEM_WAIT=1/CNT_W=32 and MEM_WAIT=0/CNT_W=4)
// driven by directed and random instructions against a per-instruction cycle-trace model.
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] st;
        logic irw, pcw, rgw, mrd, mwr, ior, iow, m2r, asrc, jl, jr, br;
        logic [2:0] aop;
        logic ioreq, hlt, ill;
    } obs_t;

    localparam logic [21:0] PREFIX = 22'h3FFFFE;
    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4, K_JAL = 5,
                   K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ECALL = 9, K_EBREAK = 10, K_BAD = 11;

    logic        clk = 1'b0;
    logic        rst_v   [2];
    logic [31:0] inst_v  [2];
    logic [21:0] arh_v   [2];
    logic        ack_v   [2];
    obs_t        obs_v   [2];
    logic [31:0] ret_v   [2];
    logic [31:0] exp_ret [2];
    logic [31:0] cmask   [2];
    int          mw_of   [2];
    int          n_total = 0;
    int          n_bad   = 0;

    obs_t        exp_q[$];
    logic        ack_q[$];
    logic [31:0] ins_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int MW = (g == 0) ? 1 : 0;
        localparam int CW = (g == 0) ? 32 : 4;
        logic [CW-1:0] ret_s;
        logic [2:0] st_s, aop_s;
        logic irw_s, pcw_s, rgw_s, mrd_s, mwr_s, ior_s, iow_s, m2r_s, asrc_s, jl_s, jr_s, br_s;
        logic ioreq_s, hlt_s, ill_s;

        multicycle_controller #(.IO_HIGH_BITS(22), .IO_PREFIX(22'h3FFFFE), .MEM_WAIT(MW), .CNT_W(CW)) u_dut (
            .clk(clk), .rst(rst_v[g]), .inst(inst_v[g]), .alu_result_high(arh_v[g]), .io_ack(ack_v[g]),
            .ir_write(irw_s), .pc_write(pcw_s), .reg_write(rgw_s), .mem_read(mrd_s), .mem_write(mwr_s),
            .io_read(ior_s), .io_write(iow_s), .mem_or_io_to_reg(m2r_s), .alu_src(asrc_s), .jal(jl_s),
            .jr(jr_s), .branch(br_s), .alu_op(aop_s), .io_req(ioreq_s), .halted(hlt_s), .illegal(ill_s),
            .state(st_s), .retired(ret_s)
        );

        assign obs_v[g] = {st_s, irw_s, pcw_s, rgw_s, mrd_s, mwr_s, ior_s, iow_s, m2r_s, asrc_s,
                           jl_s, jr_s, br_s, aop_s, ioreq_s, hlt_s, ill_s};
        assign ret_v[g] = 32'(ret_s);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic int kind_of(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: kind_of = K_R;
            7'b0010011: kind_of = K_I;
            7'b0000011: kind_of = K_LOAD;
            7'b0100011: kind_of = K_STORE;
            7'b1100011: kind_of = K_BRANCH;
            7'b1101111: kind_of = K_JAL;
            7'b1100111: kind_of = K_JALR;
            7'b0110111: kind_of = K_LUI;
            7'b0010111: kind_of = K_AUIPC;
            7'b1110011: kind_of = (ins[31:20] == 12'd1) ? K_EBREAK : K_ECALL;
            default:    kind_of = K_BAD;
        endcase
    endfunction

    function automatic logic [6:0] op_of(input int k);
        case (k)
            K_R:      op_of = 7'b0110011;
            K_I:      op_of = 7'b0010011;
            K_LOAD:   op_of = 7'b0000011;
            K_STORE:  op_of = 7'b0100011;
            K_BRANCH: op_of = 7'b1100011;
            K_JAL:    op_of = 7'b1101111;
            K_JALR:   op_of = 7'b1100111;
            K_LUI:    op_of = 7'b0110111;
            K_AUIPC:  op_of = 7'b0010111;
            default:  op_of = 7'b1110011;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst(input int k);
        logic [31:0] r;
        logic [11:0] hi;
        logic [6:0]  op;
        r  = $urandom;
        hi = r[31:20];
        if (k == K_EBREAK) return {12'd1, r[19:7], 7'b1110011};
        if (k == K_ECALL) begin
            if (hi == 12'd1) hi = 12'd0;
            return {hi, r[19:7], 7'b1110011};
        end
        if (k == K_BAD) begin
            op = 7'($urandom_range(0, 127));
            while (kind_of({25'd0, op}) != K_BAD) op = 7'($urandom_range(0, 127));
            return {r[31:7], op};
        end
        return {r[31:7], op_of(k)};
    endfunction

    function automatic logic [21:0] rand_arh(input logic io);
        logic [21:0] v;
        if (io) return PREFIX;
        v = ($urandom_range(0, 1) == 0) ? 22'($urandom) : (PREFIX ^ (22'd1 << $urandom_range(0, 21)));
        if (v == PREFIX) v = v ^ 22'd1;
        return v;
    endfunction

    task automatic put(input obs_t o, input logic a, input logic [31:0] i);
        exp_q.push_back(o); ack_q.push_back(a); ins_q.push_back(i);
    endtask

    // Reference trace: expected outputs, io_ack drive and inst drive for every cycle of one instruction
    task automatic build(input int mw, input logic [31:0] ins, input logic io, input int ackd, input int park);
        obs_t o;
        int k;
        k = kind_of(ins);
        exp_q.delete(); ack_q.delete(); ins_q.delete();
        for (int i = 0; i <= mw; i++) begin
            o = '0; o.st = 3'd0; o.irw = (i == mw);
            put(o, 1'($urandom_range(0, 1)), ins);
        end
        o = '0; o.st = 3'd1;
        put(o, 1'($urandom_range(0, 1)), ins);
        if (k == K_EBREAK || k == K_BAD) begin
            for (int i = 0; i < park; i++) begin
                o = '0;
                o.st  = (k == K_EBREAK) ? 3'd6 : 3'd7;
                o.hlt = (k == K_EBREAK);
                o.ill = (k == K_BAD);
                put(o, 1'($urandom_range(0, 1)), $urandom);
            end
        end else if (k == K_ECALL) begin
            for (int i = 0; i <= ackd; i++) begin
                o = '0; o.st = 3'd5; o.iow = 1'b1; o.ioreq = 1'b1; o.aop = 3'b100; o.asrc = 1'b1;
                o.pcw = (i == ackd);
                put(o, (i == ackd), ins);
            end
        end else begin
            o = '0; o.st = 3'd2;
            o.asrc = (k != K_R) && (k != K_BRANCH);
            case (k)
                K_R, K_I: o.aop = 3'b010;
                K_BRANCH: o.aop = 3'b001;
                K_LUI:    o.aop = 3'b011;
                K_AUIPC:  o.aop = 3'b110;
                default:  o.aop = 3'b000;
            endcase
            o.br  = (k == K_BRANCH);
            o.pcw = (k == K_BRANCH);
            put(o, 1'($urandom_range(0, 1)), ins);
            if (k == K_LOAD || k == K_STORE) begin
                for (int i = 0; i <= mw; i++) begin
                    o = '0; o.st = 3'd3;
                    o.mrd = (k == K_LOAD) && !io;  o.ior = (k == K_LOAD) && io;
                    o.mwr = (k == K_STORE) && !io; o.iow = (k == K_STORE) && io;
                    o.pcw = (k == K_STORE) && (i == mw);
                    put(o, 1'($urandom_range(0, 1)), ins);
                end
            end
            if (k != K_BRANCH && k != K_STORE) begin
                o = '0; o.st = 3'd4; o.rgw = 1'b1; o.pcw = 1'b1;
                o.m2r = (k == K_LOAD); o.jl = (k == K_JAL) || (k == K_JALR); o.jr = (k == K_JALR);
                put(o, 1'($urandom_range(0, 1)), ins);
            end
        end
    endtask

    // Plays the queued trace on instance d; call positioned 1 time unit after a rising edge
    task automatic run(input int d, input int limit);
        for (int i = 0; i < exp_q.size() && i < limit; i++) begin
            inst_v[d] = ins_q[i];
            ack_v[d]  = ack_q[i];
            @(negedge clk);
            check_val($sformatf("d%0d_c%0d_out", d, i), 64'(obs_v[d]), 64'(exp_q[i]));
            check_val($sformatf("d%0d_c%0d_ret", d, i), 64'(ret_v[d]), 64'(exp_ret[d]));
            if (exp_q[i].pcw) exp_ret[d] = (exp_ret[d] + 32'd1) & cmask[d];
            @(posedge clk); #1;
        end
        ack_v[d] = 1'b0;
    endtask

    task automatic one(input int d, input logic [31:0] ins, input logic io, input int ackd, input int park);
        arh_v[d] = rand_arh(io);
        build(mw_of[d], ins, io, ackd, park);
        run(d, 1000);
    endtask

    task automatic do_reset(input int d, input int n);
        rst_v[d]  = 1'b1;
        inst_v[d] = $urandom;
        ack_v[d]  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            check_val($sformatf("d%0d_rst%0d_out", d, i), 64'(obs_v[d]), 64'd0);
            check_val($sformatf("d%0d_rst%0d_ret", d, i), 64'(ret_v[d]), 64'd0);
            @(posedge clk); #1;
        end
        rst_v[d]   = 1'b0;
        ack_v[d]   = 1'b0;
        exp_ret[d] = 32'd0;
    endtask

    task automatic random_run(input int d, input int count);
        int k;
        for (int n = 0; n < count; n++) begin
            k = $urandom_range(K_R, K_ECALL);
            one(d, rand_inst(k), 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
            if ($urandom_range(0, 39) == 0) do_reset(d, $urandom_range(2, 4));
        end
    endtask

    initial begin
        cmask[0] = 32'hFFFF_FFFF; cmask[1] = 32'h0000_000F;
        mw_of[0] = 1;             mw_of[1] = 0;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; inst_v[d] = 32'd0; arh_v[d] = 22'd0; ack_v[d] = 1'b0; exp_ret[d] = 32'd0;
        end

        // Instance 0: MEM_WAIT=1
        do_reset(0, 4);
        one(0, 32'h003100B3, 1'b0, 0, 0);               // add x1,x2,x3
        one(0, 32'h00002083, 1'b1, 0, 0);               // lw, IO region
        one(0, 32'h00002083, 1'b0, 0, 0);               // lw, memory
        arh_v[0] = 22'd0;
        build(1, 32'h00000073, 1'b0, 3, 0);             // ecall, ack 3 cycles after entry
        ack_q[0] = 1'b1; ack_q[1] = 1'b1;
        run(0, 1000);
        arh_v[0] = 22'd0;
        build(1, 32'h00112823, 1'b0, 0, 0);             // sw, aborted on its 2nd MEM cycle
        run(0, 5);
        do_reset(0, 4);
        random_run(0, 150);
        one(0, 32'h00100073, 1'b0, 0, 20);              // ebreak parks in HALT
        do_reset(0, 4);
        one(0, 32'h0000007F, 1'b0, 0, 6);               // unknown opcode parks in TRAP
        do_reset(0, 3);
        one(0, rand_inst(K_BAD), 1'b0, 0, 4);
        do_reset(0, 3);
        one(0, 32'h003100B3, 1'b0, 0, 0);
        rst_v[0] = 1'b1;

        // Instance 1: MEM_WAIT=0, 4-bit retired counter to exercise wrap
        do_reset(1, 4);
        one(1, 32'h00112823, 1'b0, 0, 0);               // sw to 0x10
        one(1, 32'h00112823, 1'b1, 0, 0);
        one(1, 32'h00000073, 1'b0, 0, 0);               // ecall acked on entry
        random_run(1, 60);
        one(1, 32'h00100073, 1'b0, 0, 5);
        do_reset(1, 4);
        one(1, 32'h0000007F, 1'b0, 0, 3);
        do_reset(1, 4);
        one(1, 32'h00002083, 1'b1, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
